bram_param_loader: RTL and testbench

BRAM_PARAM_LOADER -- requirements
Module: bram_param_loader

---
 rtl/bram_param_loader.sv | 121 ++++++++++++
 tb/tb_bram_param_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bram_param_loader.sv
// bram_param_loader: reads COUNT consecutive BRAM words starting at BASE_ADDR and
// unpacks them, zero- or sign-extended to OUT_W bits, into a flat parameter vector.
module bram_param_loader #(
  parameter int W          = 8,
  parameter int COUNT      = 8,
  parameter int OUT_W      = 8,
  parameter int SIGN_EXT   = 0,
  parameter int BASE_ADDR  = 147536,
  parameter int ADDR_WIDTH = 18,
  parameter int RD_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   bram_en,
  output logic                   bram_ren,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  input  logic [W-1:0]           bram_dout,
  output logic [COUNT*OUT_W-1:0] data_out
);

  localparam int CNT_MAX = (COUNT > RD_LATENCY) ? COUNT : RD_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(COUNT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [OUT_W-1:0]      slot_q [COUNT];
  logic [OUT_W-1:0]      ext_word;
  logic                  wr_en;

  // The oldest valid bit marks the cycle in which bram_dout carries a requested word.
  assign wr_en     = vld_q[RD_LATENCY-1];
  assign bram_addr = addr_q;
  assign ext_word  = (SIGN_EXT != 0) ? OUT_W'($signed(bram_dout)) : OUT_W'(bram_dout);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_ptr_d = wr_ptr_q;
    vld_d    = RD_LATENCY'({vld_q, state_q == ISSUE});
    busy     = 1'b0;
    done     = 1'b0;
    bram_en  = 1'b0;
    bram_ren = 1'b0;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case (state_q)
      IDLE, DONE: begin
        done = (state_q == DONE);
        if (start) begin
          state_d  = ISSUE;
          cnt_d    = '0;
          addr_d   = ADDR_WIDTH'(BASE_ADDR);
          wr_ptr_d = '0;
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        bram_en  = 1'b1;
        bram_ren = 1'b1;
        addr_d   = addr_q + ADDR_WIDTH'(1);
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(COUNT - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        bram_en = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= ADDR_WIDTH'(BASE_ADDR);
      wr_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      vld_q    <= vld_d;
    end
  end

  // NOTE: the slot array is flops, not RAM, and must read zero during reset, so it is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < COUNT; i++) slot_q[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < COUNT; i++)
        if (wr_ptr_q == PTR_W'(i)) slot_q[i] <= ext_word;
    end
  end

  for (genvar i = 0; i < COUNT; i++) begin : g_pack
    assign data_out[i*OUT_W +: OUT_W] = slot_q[i];
  end

endmodule

// File: tb/tb_bram_param_loader.sv
// Self-checking bench for bram_param_loader: four configurations share one clock,
// each fed by a behavioural BRAM returning mem[a] = a[7:0] after its read latency.
module tb_bram_param_loader;

  localparam int BASE = 147536;
  localparam int LAT [4] = '{2, 2, 1, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        st    [4];
  logic        busy  [4];
  logic        done  [4];
  logic        en    [4];
  logic        ren   [4];
  logic [17:0] addr  [4];
  logic [7:0]  dout  [4];
  logic [7:0]  pipe  [4][4];
  logic [63:0] data_def, data_sx;
  logic [7:0]  data_l1, data_l4;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cur      = 0;
  bit          mon_on   = 1'b0;
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;

  bram_param_loader u_def (
    .clk(clk), .rst(rst), .start(st[0]), .busy(busy[0]), .done(done[0]),
    .bram_en(en[0]), .bram_ren(ren[0]), .bram_addr(addr[0]), .bram_dout(dout[0]),
    .data_out(data_def));

  bram_param_loader #(.OUT_W(16), .SIGN_EXT(1), .BASE_ADDR(32'h7E), .COUNT(4)) u_sx (
    .clk(clk), .rst(rst), .start(st[1]), .busy(busy[1]), .done(done[1]),
    .bram_en(en[1]), .bram_ren(ren[1]), .bram_addr(addr[1]), .bram_dout(dout[1]),
    .data_out(data_sx));

  bram_param_loader #(.COUNT(1), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .start(st[2]), .busy(busy[2]), .done(done[2]),
    .bram_en(en[2]), .bram_ren(ren[2]), .bram_addr(addr[2]), .bram_dout(dout[2]),
    .data_out(data_l1));

  bram_param_loader #(.COUNT(1), .RD_LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .start(st[3]), .busy(busy[3]), .done(done[3]),
    .bram_en(en[3]), .bram_ren(ren[3]), .bram_addr(addr[3]), .bram_dout(dout[3]),
    .data_out(data_l4));

  // BRAM models: the pipeline advances while enabled; data is not reset.
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (en[j]) begin
        for (int s = 3; s > 0; s--) pipe[j][s] <= pipe[j][s-1];
        if (ren[j]) pipe[j][0] <= addr[j][7:0];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) dout[j] = pipe[j][LAT[j]-1];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every issued read is popped against the expected address.
  always @(negedge clk) begin
    if (mon_on) begin
      if (ren[cur]) begin
        if (exp_q.size() > 0) check("addr", 64'(addr[cur]), 64'(exp_q.pop_front()));
        else                  check("addr_unexpected", 64'(ren[cur]), 64'd0);
      end
      check("busy_done_excl", 64'(busy[cur] & done[cur]), 64'd0);
    end
  end

  // One load on instance j; with pulse set, start is re-raised during ISSUE and DRAIN.
  task automatic run_load(input int j, input int cnt, input int lat, input int base,
                          input bit pulse);
    int n;
    bit seen;
    for (int k = 0; k < cnt; k++) exp_q.push_back(18'(base + k));
    cur = j;
    @(negedge clk) st[j] = 1'b1;
    @(posedge clk);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < cnt + lat + 20) begin
      @(negedge clk);
      st[j] = pulse && (n == 2 || n == cnt);
      if (done[j]) begin
        seen = 1'b1;
        check("done_latency", 64'(n), 64'(cnt + lat));
        check("en_after_done", 64'(en[j]), 64'd0);
      end else begin
        check("busy_in_load", 64'(busy[j]), 64'd1);
        check("en_in_load", 64'(en[j]), 64'd1);
        check("ren_phase", 64'(ren[j]), 64'(n < cnt));
      end
      n++;
    end
    if (!seen) check("done_timeout", 64'(done[j]), 64'd1);
    check("addr_left", 64'(exp_q.size()), 64'd0);
  endtask

  logic [63:0] exp_def;

  initial begin
    rst = 1'b1;
    for (int j = 0; j < 4; j++) st[j] = 1'b0;
    for (int i = 0; i < 8; i++) exp_def[i*8 +: 8] = 8'h50 + 8'(i);

    #3;
    check("rst_busy", 64'(busy[0]), 64'd0);
    check("rst_done", 64'(done[0]), 64'd0);
    check("rst_en", 64'(en[0] | ren[0]), 64'd0);
    check("rst_addr", 64'(addr[0]), 64'(BASE));
    check("rst_data", data_def, 64'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_hold", 64'({busy[0], done[0]}), 64'd0);
    mon_on = 1'b1;

    run_load(0, 8, 2, BASE, 1'b0);
    check("data_def", data_def, exp_def);

    run_load(0, 8, 2, BASE, 1'b1);
    check("data_def_pulse", data_def, exp_def);

    // start held high: done must be a single-cycle gap between two loads.
    for (int k = 0; k < 16; k++) exp_q.push_back(18'(BASE + (k % 8)));
    cur = 0;
    @(negedge clk) st[0] = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 22; n++) begin
      @(negedge clk);
      check("hold_done", 64'(done[0]), 64'(n == 10 || n == 21));
      if (n == 12) check("hold_not_cleared", data_def, exp_def);
      if (n == 21) st[0] = 1'b0;
    end
    @(negedge clk);
    check("done_level", 64'(done[0]), 64'd1);
    check("hold_addr_left", 64'(exp_q.size()), 64'd0);

    // Reset three cycles into ISSUE.
    for (int k = 0; k < 8; k++) exp_q.push_back(18'(BASE + k));
    @(negedge clk) st[0] = 1'b1;
    @(posedge clk);
    @(negedge clk) st[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy[0]), 64'd0);
    check("arst_en", 64'({en[0], ren[0]}), 64'd0);
    check("arst_addr", 64'(addr[0]), 64'(BASE));
    check("arst_data", data_def, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_data", data_def, 64'd0);
    check("post_rst_idle", 64'({busy[0], done[0]}), 64'd0);
    run_load(0, 8, 2, BASE, 1'b0);
    check("data_after_rst", data_def, exp_def);

    run_load(1, 4, 2, 32'h7E, 1'b0);
    check("data_sx", data_sx, 64'hFF81_FF80_007F_007E);

    run_load(2, 1, 1, BASE, 1'b0);
    check("data_l1", 64'(data_l1), 64'h50);

    run_load(3, 1, 4, BASE, 1'b0);
    check("data_l4", 64'(data_l4), 64'h50);

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
